cordic_tune_ctrl: RTL and testbench

//  Tuning controller for the CORDIC NCO/mixer. Accepts retune requests over a valid/ready handshake.

---
 rtl/cordic_ctrl_pkg.sv | 30 +++
 rtl/cordic_tune_ctrl_if.sv | 40 ++++
 rtl/cordic_ramp_gen.sv | 102 ++++++++++
 rtl/cordic_tune_ctrl.sv | 108 ++++++++++
 tb/tb_cordic_tune_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cordic_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_ctrl_pkg
//  Description : Shared types and constants for the CORDIC tuning controller.
//                Holds the FSM state encoding, the default frequency-word
//                width, a 30-degree phase-increment constant and a helper
//                that converts log2(step count) into a step count.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_ctrl_pkg;

  localparam int FREQ_W_DEFAULT = 32;

  // Phase increment for 30 degrees per cycle (2^32 / 12).
  localparam logic [31:0] DEG30 = 32'h1555_5555;

  // Step counter is 16 bits: up to 2^15 steps plus the terminal value.
  localparam int STEP_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RAMP   = 2'd1;
  localparam state_t ST_SETTLE = 2'd2;

  function automatic logic [STEP_W-1:0] steps_of(input logic [3:0] log2_steps);
    return STEP_W'(1) << log2_steps;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_tune_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_tune_ctrl_if
//  Description : Control-plane bundle for the CORDIC tuning controller.
//                master : control plane (issues retune requests / abort)
//                slave  : cordic_tune_ctrl
//  Signals     : req_valid/req_ready handshake, req_freq target word,
//                req_log2_steps ramp length, req_phase_clr, abort,
//                frequency/phase_clr toward the CORDIC, busy/tuned status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_tune_ctrl_if
  import cordic_ctrl_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEFAULT
);

  logic              req_valid;
  logic              req_ready;
  logic [FREQ_W-1:0] req_freq;
  logic [3:0]        req_log2_steps;
  logic              req_phase_clr;
  logic              abort;
  logic [FREQ_W-1:0] frequency;
  logic              phase_clr;
  logic              busy;
  logic              tuned;

  modport master (
    output req_valid, req_freq, req_log2_steps, req_phase_clr, abort,
    input  req_ready, frequency, phase_clr, busy, tuned
  );

  modport slave (
    input  req_valid, req_freq, req_log2_steps, req_phase_clr, abort,
    output req_ready, frequency, phase_clr, busy, tuned
  );

endinterface
`default_nettype wire

// File: rtl/cordic_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_ramp_gen
//  Description : Linear frequency-word ramp. On i_start it latches the target
//                and a per-step increment (|delta| >> k, sign restored, so
//                truncation is toward zero and never overshoots), then
//                advances o_freq every DWELL cycles for 2^k steps, landing
//                exactly on the target at the last step.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                i_start         - request accepted this cycle
//                i_abort         - stop ramp, hold current o_freq
//                i_target        - target frequency word
//                i_log2_steps    - k, ramp uses 2^k steps
//                o_freq          - registered frequency word
//                o_last_step     - final step happens on the coming edge
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_ramp_gen
  import cordic_ctrl_pkg::*;
#(
  parameter int FREQ_W = FREQ_W_DEFAULT,
  parameter int DWELL  = 1
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_start,
  input  wire logic              i_abort,
  input  wire logic [FREQ_W-1:0] i_target,
  input  wire logic [3:0]        i_log2_steps,
  output logic      [FREQ_W-1:0] o_freq,
  output logic                   o_last_step
);

  localparam int            DW_W         = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] C_DWELL_LAST = DW_W'(DWELL - 1);

  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] r_target;
  logic [FREQ_W-1:0] r_inc;
  logic [STEP_W-1:0] r_nsteps;
  logic [STEP_W-1:0] r_step;
  logic [DW_W-1:0]   r_dwell;
  logic              r_active;

  logic [FREQ_W:0]   w_delta;
  logic              w_neg;
  logic [FREQ_W-1:0] w_mag;
  logic [FREQ_W-1:0] w_mag_sh;
  logic [FREQ_W-1:0] w_inc;
  logic              w_dwell_done;
  logic              w_last;

  // Signed 33-bit difference; magnitude always fits in FREQ_W bits.
  assign w_delta  = {1'b0, i_target} - {1'b0, r_freq};
  assign w_neg    = w_delta[FREQ_W];
  assign w_mag    = w_neg ? (~w_delta[FREQ_W-1:0] + FREQ_W'(1)) : w_delta[FREQ_W-1:0];
  // Shift the magnitude, not the signed value, so the step rounds toward zero.
  assign w_mag_sh = w_mag >> i_log2_steps;
  assign w_inc    = w_neg ? (-w_mag_sh) : w_mag_sh;

  assign w_dwell_done = (r_dwell == C_DWELL_LAST);
  assign w_last       = (r_step == (r_nsteps - STEP_W'(1)));
  assign o_last_step  = r_active && w_dwell_done && w_last && !i_abort;
  assign o_freq       = r_freq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq   <= '0;
      r_target <= '0;
      r_inc    <= '0;
      r_nsteps <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_target <= i_target;
      r_inc    <= w_inc;
      r_nsteps <= steps_of(i_log2_steps);
      r_step   <= '0;
      r_dwell  <= '0;
      r_active <= 1'b1;
    end else if (i_abort) begin
      r_active <= 1'b0;
    end else if (r_active) begin
      if (w_dwell_done) begin
        r_dwell <= '0;
        if (w_last) begin
          // Final step lands exactly on the target, absorbing truncation error.
          r_freq   <= r_target;
          r_active <= 1'b0;
        end else begin
          r_freq <= r_freq + r_inc;
          r_step <= r_step + STEP_W'(1);
        end
      end else begin
        r_dwell <= r_dwell + DW_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_tune_ctrl
//  Description : Tuning controller for the CORDIC NCO/mixer. Accepts retune
//                requests, ramps the frequency word via cordic_ramp_gen,
//                optionally pulses a phase-accumulator clear at the target,
//                waits PIPE_LAT cycles for the CORDIC pipeline, then flags
//                the output as tuned.
//  Ports       : CLK_12MHz - system clock (rising edge)
//                RST_N     - asynchronous active-low reset
//                bus       - cordic_tune_ctrl_if slave modport
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_tune_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int FREQ_W   = FREQ_W_DEFAULT,
  parameter int DWELL    = 1,
  parameter int PIPE_LAT = 16
) (
  input  wire logic          CLK_12MHz,
  input  wire logic          RST_N,
  cordic_tune_ctrl_if.slave  bus
);

  localparam int               SET_W         = $clog2(PIPE_LAT + 1);
  localparam logic [SET_W-1:0] C_SETTLE_LAST = SET_W'(PIPE_LAT - 1);

  state_t            r_state;
  logic [SET_W-1:0]  r_settle;
  logic              r_pclr_flag;
  logic              r_phase_clr;
  logic              r_tuned;

  logic              w_idle;
  logic              w_accept;
  logic              w_abort;
  logic              w_last_step;
  logic [FREQ_W-1:0] w_freq;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && bus.req_valid && !bus.abort;
  // abort only has an effect while a ramp or settle is in progress.
  assign w_abort  = bus.abort && !w_idle;

  assign bus.req_ready = w_idle && !bus.abort;
  assign bus.busy      = !w_idle;
  assign bus.frequency = w_freq;
  assign bus.phase_clr = r_phase_clr;
  assign bus.tuned     = r_tuned;

  cordic_ramp_gen #(
    .FREQ_W (FREQ_W),
    .DWELL  (DWELL)
  ) u_ramp (
    .clk          (CLK_12MHz),
    .rst_n        (RST_N),
    .i_start      (w_accept),
    .i_abort      (w_abort),
    .i_target     (bus.req_freq),
    .i_log2_steps (bus.req_log2_steps),
    .o_freq       (w_freq),
    .o_last_step  (w_last_step)
  );

  always_ff @(posedge CLK_12MHz or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_settle    <= '0;
      r_pclr_flag <= 1'b0;
      r_phase_clr <= 1'b0;
      r_tuned     <= 1'b0;
    end else begin
      r_phase_clr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_pclr_flag <= bus.req_phase_clr;
            r_tuned     <= 1'b0;
            r_state     <= ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (w_last_step) begin
            r_phase_clr <= r_pclr_flag;
            r_settle    <= '0;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
          end else if (r_settle == C_SETTLE_LAST) begin
            r_tuned <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_settle <= r_settle + SET_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_tune_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_tune_ctrl
//  Description : Directed self-checking bench for cordic_tune_ctrl.
//                u_dut_a: DWELL=1, PIPE_LAT=16. u_dut_b: DWELL=3, PIPE_LAT=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_tune_ctrl;
  import cordic_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_tune_ctrl_if #(.FREQ_W(32)) bus_a ();
  cordic_tune_ctrl_if #(.FREQ_W(32)) bus_b ();

  cordic_tune_ctrl #(.FREQ_W(32), .DWELL(1), .PIPE_LAT(16)) u_dut_a (
    .CLK_12MHz (clk),
    .RST_N     (rst_n),
    .bus       (bus_a.slave)
  );

  cordic_tune_ctrl #(.FREQ_W(32), .DWELL(3), .PIPE_LAT(16)) u_dut_b (
    .CLK_12MHz (clk),
    .RST_N     (rst_n),
    .bus       (bus_b.slave)
  );

  int   n_cmp   = 0;
  int   n_err   = 0;
  logic pc_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge; track any phase_clr on A.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_a.phase_clr === 1'b1) pc_seen = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic req_a(input logic [31:0] f, input logic [3:0] k, input logic pclr);
    bus_a.req_valid      = 1'b1;
    bus_a.req_freq       = f;
    bus_a.req_log2_steps = k;
    bus_a.req_phase_clr  = pclr;
    tick();
    bus_a.req_valid      = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] down_exp [4];

  initial begin
    bus_a.req_valid = 1'b0; bus_a.req_freq = '0; bus_a.req_log2_steps = '0;
    bus_a.req_phase_clr = 1'b0; bus_a.abort = 1'b0;
    bus_b.req_valid = 1'b0; bus_b.req_freq = '0; bus_b.req_log2_steps = '0;
    bus_b.req_phase_clr = 1'b0; bus_b.abort = 1'b0;
    down_exp[0] = 32'hF; down_exp[1] = 32'hB; down_exp[2] = 32'h7; down_exp[3] = 32'h0;

    // Reset state
    run(3);
    chk("rst_freq",  bus_a.frequency, 0);
    chk("rst_busy",  bus_a.busy, 0);
    chk("rst_tuned", bus_a.tuned, 0);
    chk("rst_pclr",  bus_a.phase_clr, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", bus_a.req_ready, 1);

    // 1: single-step jump to 30 degrees
    pc_seen = 1'b0;
    req_a(DEG30, 4'd0, 1'b0);
    chk("j_busy",  bus_a.busy, 1);
    chk("j_ready", bus_a.req_ready, 0);
    tick();
    chk("j_freq",  bus_a.frequency, 32'h1555_5555);
    run(15);
    chk("j_tuned16", bus_a.tuned, 0);
    tick();
    chk("j_tuned17", bus_a.tuned, 1);
    chk("j_idle",    bus_a.busy, 0);
    chk("j_nopclr",  pc_seen, 0);

    // 2: ramp up 0 -> 0x1000_0000, 16 steps
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("u_start", bus_a.frequency, 0);
    pc_seen = 1'b0;
    req_a(32'h1000_0000, 4'd4, 1'b0);
    for (int n = 1; n <= 16; n++) begin
      tick();
      chk("u_step", bus_a.frequency, 64'(n) * 64'h0100_0000);
    end
    run(15);
    chk("u_tuned31", bus_a.tuned, 0);
    tick();
    chk("u_tuned32", bus_a.tuned, 1);
    chk("u_nopclr",  pc_seen, 0);

    // 3: ramp down with truncation 0x13 -> 0, 4 steps
    req_a(32'h13, 4'd0, 1'b0);
    run(17);
    chk("d_pre_freq",  bus_a.frequency, 32'h13);
    chk("d_pre_tuned", bus_a.tuned, 1);
    req_a(32'h0, 4'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("d_step", bus_a.frequency, down_exp[i]);
    end
    run(16);
    chk("d_tuned", bus_a.tuned, 1);
    chk("d_final", bus_a.frequency, 0);

    // 5: abort at step 5 of a k=4 ramp (phase clear requested)
    pc_seen = 1'b0;
    req_a(32'h1000_0000, 4'd4, 1'b1);
    run(5);
    chk("a_step5", bus_a.frequency, 32'h0500_0000);
    bus_a.abort = 1'b1;
    tick();
    chk("a_busy",  bus_a.busy, 0);
    chk("a_freq",  bus_a.frequency, 32'h0500_0000);
    chk("a_tuned", bus_a.tuned, 0);
    bus_a.req_valid = 1'b1;
    chk("a_ready_lo", bus_a.req_ready, 0);
    tick();
    chk("a_not_acc", bus_a.busy, 0);
    bus_a.abort = 1'b0;
    bus_a.req_valid = 1'b0;
    run(30);
    chk("a_hold",    bus_a.frequency, 32'h0500_0000);
    chk("a_tuned2",  bus_a.tuned, 0);
    chk("a_nopclr",  pc_seen, 0);

    // 6: request held through busy, accepted on first idle cycle
    bus_a.req_valid      = 1'b1;
    bus_a.req_freq       = 32'h100;
    bus_a.req_log2_steps = 4'd0;
    bus_a.req_phase_clr  = 1'b0;
    tick();
    bus_a.req_freq = 32'h200;
    run(16);
    chk("b_hold_freq", bus_a.frequency, 32'h100);
    chk("b_hold_busy", bus_a.busy, 1);
    tick();
    chk("b_tuned", bus_a.tuned, 1);
    chk("b_ready", bus_a.req_ready, 1);
    chk("b_freq1", bus_a.frequency, 32'h100);
    tick();
    chk("b_acc2_busy",  bus_a.busy, 1);
    chk("b_acc2_tuned", bus_a.tuned, 0);
    tick();
    chk("b_freq2", bus_a.frequency, 32'h200);
    bus_a.req_valid = 1'b0;
    run(17);

    // Reset in mid-ramp: inc = (0x1000_0000-0x200)>>4 = 0x00FF_FFE0
    req_a(32'h1000_0000, 4'd4, 1'b0);
    run(3);
    chk("r_step3", bus_a.frequency, 32'h0300_01A0);
    #2 rst_n = 1'b0;
    #1;
    chk("r_freq",  bus_a.frequency, 0);
    chk("r_busy",  bus_a.busy, 0);
    chk("r_tuned", bus_a.tuned, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4: DWELL=3, k=1, phase clear on DUT B
    bus_b.req_valid      = 1'b1;
    bus_b.req_freq       = 32'h100;
    bus_b.req_log2_steps = 4'd1;
    bus_b.req_phase_clr  = 1'b1;
    tick();
    bus_b.req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("p_freq", bus_b.frequency, (n < 3) ? 64'h0 : (n < 6) ? 64'h80 : 64'h100);
      chk("p_pclr", bus_b.phase_clr, (n == 6) ? 64'h1 : 64'h0);
    end
    run(13);
    chk("p_tuned21", bus_b.tuned, 0);
    tick();
    chk("p_tuned22", bus_b.tuned, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
